ace_master_port: RTL and testbench
==================================

ACE_MASTER_PORT -- requirements
Module: ace_master_port

Interface
REQ-001 Parameters:
- ADDR_WIDTH, 32, request and ACE address width.
- DATA_WIDTH, 32, single-beat line data width.

REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- read_req  in  1  cache controller requests a line fill (ReadShared).
- write_req  in  1  cache controller requests a dirty-line writeback (WriteBack).
- invalid_req  in  1  cache controller requests an upgrade (CleanUnique).
- req_addr  in  ADDR_WIDTH  line address from the cache datapath.
- wb_data  in  DATA_WIDTH  victim data from the cache datapath.
- ace_ready  out  1  one-cycle completion pulse to the cache controller.
- fill_data  out  DATA_WIDTH  captured read data, held until the next read completes.
- fill_shared  out  1  captured rresp[3] (IsShared), held until the next read completes.
- resp_err  out  1  completing transaction returned a non-OKAY response; valid only with ace_ready.
- AR channel:
  - arvalid  out  1
  - arready  in  1
  - araddr  out  ADDR_WIDTH
  - arsnoop  out  4
- R channel:
  - rvalid  in  1
  - rready  out  1
  - rdata  in  DATA_WIDTH
  - rresp  in  4
- AW channel:
  - awvalid  out  1
  - awready  in  1
  - awaddr  out  ADDR_WIDTH
  - awsnoop  out  3
- W channel:
  - wvalid  out  1
  - wready  in  1
  - wdata  out  DATA_WIDTH
  - wlast  out  1
- B channel:
  - bvalid  in  1
  - bready  out  1
  - bresp  in  2
- Acknowledges:
  - rack  out  1  read acknowledge.
  - wack  out  1  write acknowledge.

Function
REQ-003 States SHALL be IDLE, AR_SEND, R_WAIT, AW_W_SEND, B_WAIT, DONE.

REQ-004 IDLE SHALL sample requests; one request is accepted per transaction.
- Priority on simultaneous assertion: write_req > invalid_req > read_req.
- Requests are ignored in all other states.

REQ-005 On acceptance, req_addr and wb_data SHALL be registered and the transaction type latched.
- Next state is AW_W_SEND (write) or AR_SEND (read or invalidate).

REQ-006 AR_SEND SHALL drive arvalid=1 with the latched araddr.
- arsnoop=4'b0001 for read, 4'b1011 for invalidate.
- araddr and arsnoop stay stable until a cycle with arvalid&&arready.
- On that handshake, move to R_WAIT.

REQ-007 R_WAIT SHALL drive rready=1.
- On rvalid&&rready, capture rresp[1:0]!=0 as a pending error and move to DONE.
- Read only: rdata is captured into fill_data and rresp[3] into fill_shared.
- Invalidate leaves fill_data and fill_shared unchanged.

REQ-008 AW_W_SEND SHALL assert awvalid and wvalid in the same cycle.
- awsnoop=3'b011, wlast=1.
- Each valid deasserts independently the cycle after its own handshake.
- The state moves to B_WAIT after both handshakes, whether they happen in the same cycle or in any order.

REQ-009 B_WAIT SHALL drive bready=1.
- On bvalid, capture bresp!=0 as a pending error and move to DONE.

REQ-010 DONE SHALL last exactly one cycle.
- ace_ready=1 and resp_err=pending error.
- rack=1 for read or invalidate; wack=1 for writeback.
- Next state is IDLE unconditionally.
- Minimum spacing between consecutive ace_ready pulses is therefore 2 cycles from DONE to the next acceptance.

REQ-011 Minimum latency: request seen in IDLE at cycle 0 gives arvalid/awvalid at cycle 1.
- With zero-wait slaves, ace_ready is asserted at cycle 3.

REQ-012 Outputs SHALL be glitch-free registered or state-decoded; no combinational path from any ACE input to any valid output.

REQ-013 A request still asserted in the DONE cycle SHALL be accepted as a new transaction in the following IDLE cycle.
- This supports writeback followed by fill.

REQ-014 Request deassertion mid-transaction SHALL NOT abort the transaction.

Reset
REQ-015 When reset=0, the block SHALL asynchronously go to IDLE.
- All valid, ready, ack, ace_ready and resp_err outputs are 0.
- araddr, awaddr, wdata, fill_data are 0; fill_shared is 0; arsnoop and awsnoop are 0; wlast is 0.

REQ-016 Reset asserted mid-transaction SHALL drop all in-flight valids immediately and discard the transaction without producing ace_ready.

Verification
REQ-017 read_req=1, req_addr=0x1000, arready=1, rvalid one cycle later with rdata=0xDEADBEEF, rresp=4'b1000.
- Expect arsnoop=0001 and araddr=0x1000.
- Expect ace_ready+rack at cycle 3, fill_data=0xDEADBEEF, fill_shared=1, resp_err=0.

REQ-018 write_req=1 with wb_data=0xA5A5A5A5, awready delayed 3 cycles, wready immediate, bresp=2'b00.
- Expect wvalid to drop after 1 cycle, awvalid held 4 cycles, and awsnoop=011.
- Expect ace_ready+wack after bvalid.

REQ-019 write_req, invalid_req and read_req all asserted together.
- Expect writeback first.
- Then, with write_req dropped, invalidate (arsnoop=1011) before read.

REQ-020 invalid_req with rresp=4'b0010 (SLVERR).
- Expect resp_err=1 coincident with ace_ready.
- Expect fill_data unchanged.

REQ-021 Reset pulled low while in R_WAIT.
- Expect rready=0 immediately and no ace_ready.
- After release, a new read completes normally.

REQ-022 write_req held through DONE with read_req rising in the DONE cycle.
- Expect a read accepted in the next IDLE cycle and a second ace_ready.

Source files
------------

// File: rtl/ace_master_port.sv
// Single-outstanding ACE master port: turns cache-controller fill, writeback and
// upgrade requests into ACE ReadShared / WriteBack / CleanUnique transactions.
module ace_master_port #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_req,
    input  logic                  write_req,
    input  logic                  invalid_req,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  ace_ready,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  fill_shared,
    output logic                  resp_err,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [3:0]            arsnoop,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [3:0]            rresp,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]            awsnoop,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wlast,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  rack,
    output logic                  wack,
    output logic [2:0]            dbg_state_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_AR_SEND   = 3'd1;
    localparam logic [2:0] S_R_WAIT    = 3'd2;
    localparam logic [2:0] S_AW_W_SEND = 3'd3;
    localparam logic [2:0] S_B_WAIT    = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    // Handshakes: a transfer happens in any cycle where valid && ready are both
    // high; valid never depends combinationally on ready and holds its payload
    // stable until that cycle.

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] fill_data_q;
    logic                  fill_shared_q;
    logic [3:0]            arsnoop_q;
    logic [2:0]            awsnoop_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  is_write_q;
    logic                  is_inv_q;
    logic                  err_q;
    logic                  accept;
    logic                  aw_ok;
    logic                  w_ok;
    logic                  unused_rresp_bit;

    assign unused_rresp_bit = rresp[2];

    assign accept = (state_q == S_IDLE) && (write_req || invalid_req || read_req);
    // Each channel is complete once its valid has gone or completes this cycle.
    assign aw_ok  = !awvalid_q || awready;
    assign w_ok   = !wvalid_q || wready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (write_req)                   state_d = S_AW_W_SEND;
                else if (invalid_req || read_req) state_d = S_AR_SEND;
            end
            S_AR_SEND:   if (arready)        state_d = S_R_WAIT;
            S_R_WAIT:    if (rvalid)         state_d = S_DONE;
            S_AW_W_SEND: if (aw_ok && w_ok)  state_d = S_B_WAIT;
            S_B_WAIT:    if (bvalid)         state_d = S_DONE;
            S_DONE:                          state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            fill_data_q   <= '0;
            fill_shared_q <= 1'b0;
            arsnoop_q     <= 4'b0000;
            awsnoop_q     <= 3'b000;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            is_write_q    <= 1'b0;
            is_inv_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q     <= req_addr;
                data_q     <= wb_data;
                is_write_q <= write_req;
                is_inv_q   <= !write_req && invalid_req;
                err_q      <= 1'b0;
                if (write_req) begin
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                    awsnoop_q <= 3'b011;
                end else begin
                    arsnoop_q <= invalid_req ? 4'b1011 : 4'b0001;
                end
            end
            if (awvalid_q && awready) awvalid_q <= 1'b0;
            if (wvalid_q && wready)   wvalid_q  <= 1'b0;
            if (state_q == S_R_WAIT && rvalid) begin
                err_q <= |rresp[1:0];
                // An upgrade carries no line data, so the last fill is kept.
                if (!is_inv_q) begin
                    fill_data_q   <= rdata;
                    fill_shared_q <= rresp[3];
                end
            end
            if (state_q == S_B_WAIT && bvalid) err_q <= |bresp;
        end
    end

    assign arvalid     = (state_q == S_AR_SEND);
    assign araddr      = addr_q;
    assign arsnoop     = arsnoop_q;
    assign rready      = (state_q == S_R_WAIT);
    assign awvalid     = awvalid_q;
    assign awaddr      = addr_q;
    assign awsnoop     = awsnoop_q;
    assign wvalid      = wvalid_q;
    assign wdata       = data_q;
    assign wlast       = wvalid_q;
    assign bready      = (state_q == S_B_WAIT);
    assign ace_ready   = (state_q == S_DONE);
    assign resp_err    = (state_q == S_DONE) && err_q;
    assign rack        = (state_q == S_DONE) && !is_write_q;
    assign wack        = (state_q == S_DONE) && is_write_q;
    assign fill_data   = fill_data_q;
    assign fill_shared = fill_shared_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ace_master_port.sv
// Directed bench for ace_master_port: reset, fill, writeback, priority,
// error response, mid-transaction reset and back-to-back requests.
module tb_ace_master_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_req, write_req, invalid_req;
    logic [31:0] req_addr, wb_data;
    logic        ace_ready;
    logic [31:0] fill_data;
    logic        fill_shared, resp_err;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [3:0]  arsnoop;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [3:0]  rresp;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [2:0]  awsnoop;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic        wlast;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        rack, wack;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ace_master_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
        .req_addr(req_addr), .wb_data(wb_data),
        .ace_ready(ace_ready), .fill_data(fill_data), .fill_shared(fill_shared),
        .resp_err(resp_err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsnoop(arsnoop),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsnoop(awsnoop),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .rack(rack), .wack(wack), .dbg_state_o(dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if ({arvalid, rready, awvalid, wvalid, bready, rack, wack, ace_ready, resp_err} !== 9'b0) begin
            n_err++; $display("FAIL reset_ctrl got %b exp %b", {arvalid, rready, awvalid, wvalid, bready, rack, wack, ace_ready, resp_err}, 9'b0); end
        n_cmp++; if ({araddr, awaddr, wdata, fill_data} !== 128'h0) begin
            n_err++; $display("FAIL reset_data got %h exp 0", {araddr, awaddr, wdata, fill_data}); end
        n_cmp++; if ({fill_shared, arsnoop, awsnoop, wlast} !== 9'b0) begin
            n_err++; $display("FAIL reset_misc got %b exp %b", {fill_shared, arsnoop, awsnoop, wlast}, 9'b0); end
        n_cmp++; if (dbg_state !== 3'd0) begin
            n_err++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    endtask

    task automatic test_read();
        tick(); read_req = 1; req_addr = 32'h1000; arready = 1;
        tick(); read_req = 0;
        n_cmp++; if (arvalid !== 1'b1) begin n_err++; $display("FAIL rd_arvalid got %b exp 1", arvalid); end
        n_cmp++; if (araddr !== 32'h1000) begin n_err++; $display("FAIL rd_araddr got %h exp 1000", araddr); end
        n_cmp++; if (arsnoop !== 4'b0001) begin n_err++; $display("FAIL rd_arsnoop got %b exp 0001", arsnoop); end
        tick(); arready = 0;
        n_cmp++; if ({arvalid, rready, ace_ready} !== 3'b010) begin n_err++; $display("FAIL rd_rwait got %b exp 010", {arvalid, rready, ace_ready}); end
        rvalid = 1; rdata = 32'hDEADBEEF; rresp = 4'b1000;
        tick(); rvalid = 0;
        n_cmp++; if ({ace_ready, rack, wack, resp_err} !== 4'b1100) begin n_err++; $display("FAIL rd_done got %b exp 1100", {ace_ready, rack, wack, resp_err}); end
        n_cmp++; if (fill_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_fill got %h exp deadbeef", fill_data); end
        n_cmp++; if (fill_shared !== 1'b1) begin n_err++; $display("FAIL rd_shared got %b exp 1", fill_shared); end
        tick();
        n_cmp++; if (ace_ready !== 1'b0) begin n_err++; $display("FAIL rd_pulse got %b exp 0", ace_ready); end
    endtask

    task automatic test_write();
        tick(); write_req = 1; req_addr = 32'h2000; wb_data = 32'hA5A5A5A5; wready = 1; awready = 0;
        tick(); write_req = 0;
        n_cmp++; if ({awvalid, wvalid, wlast} !== 3'b111) begin n_err++; $display("FAIL wr_valids got %b exp 111", {awvalid, wvalid, wlast}); end
        n_cmp++; if (awsnoop !== 3'b011) begin n_err++; $display("FAIL wr_awsnoop got %b exp 011", awsnoop); end
        n_cmp++; if ({awaddr, wdata} !== {32'h2000, 32'hA5A5A5A5}) begin n_err++; $display("FAIL wr_payload got %h exp %h", {awaddr, wdata}, {32'h2000, 32'hA5A5A5A5}); end
        for (int i = 2; i <= 4; i++) begin
            tick();
            n_cmp++; if ({awvalid, wvalid} !== 2'b10) begin n_err++; $display("FAIL wr_hold_c%0d got %b exp 10", i, {awvalid, wvalid}); end
        end
        awready = 1;
        tick(); awready = 0;
        n_cmp++; if ({awvalid, bready, ace_ready} !== 3'b010) begin n_err++; $display("FAIL wr_bwait got %b exp 010", {awvalid, bready, ace_ready}); end
        bvalid = 1; bresp = 2'b00;
        tick(); bvalid = 0;
        n_cmp++; if ({ace_ready, wack, rack, resp_err} !== 4'b1100) begin n_err++; $display("FAIL wr_done got %b exp 1100", {ace_ready, wack, rack, resp_err}); end
        tick();
    endtask

    task automatic test_priority();
        tick(); write_req = 1; invalid_req = 1; read_req = 1; req_addr = 32'h3000; wb_data = 32'h11112222;
        awready = 1; wready = 1;
        tick(); write_req = 0;
        n_cmp++; if ({awvalid, arvalid} !== 2'b10) begin n_err++; $display("FAIL pri_write_first got %b exp 10", {awvalid, arvalid}); end
        tick(); awready = 0; bvalid = 1; bresp = 2'b00;
        tick(); bvalid = 0; arready = 1;
        n_cmp++; if ({ace_ready, wack} !== 2'b11) begin n_err++; $display("FAIL pri_wb_done got %b exp 11", {ace_ready, wack}); end
        tick();
        n_cmp++; if ({arvalid, ace_ready} !== 2'b00) begin n_err++; $display("FAIL pri_idle got %b exp 00", {arvalid, ace_ready}); end
        tick(); invalid_req = 0;
        n_cmp++; if ({arvalid, arsnoop} !== 5'b1_1011) begin n_err++; $display("FAIL pri_inv_ar got %b exp 11011", {arvalid, arsnoop}); end
        tick(); rvalid = 1; rdata = 32'h00000055; rresp = 4'b0000;
        tick(); rvalid = 0;
        n_cmp++; if ({ace_ready, rack, fill_data, fill_shared} !== {2'b11, 32'hDEADBEEF, 1'b1}) begin
            n_err++; $display("FAIL pri_inv_done got %b/%h/%b exp 11/deadbeef/1", {ace_ready, rack}, fill_data, fill_shared); end
        tick();
        tick(); read_req = 0;
        n_cmp++; if ({arvalid, arsnoop} !== 5'b1_0001) begin n_err++; $display("FAIL pri_rd_ar got %b exp 10001", {arvalid, arsnoop}); end
        tick(); rvalid = 1; rdata = 32'h12345678; rresp = 4'b0000;
        tick(); rvalid = 0; arready = 0;
        n_cmp++; if ({ace_ready, rack, fill_data, fill_shared} !== {2'b11, 32'h12345678, 1'b0}) begin
            n_err++; $display("FAIL pri_rd_done got %b/%h/%b exp 11/12345678/0", {ace_ready, rack}, fill_data, fill_shared); end
        tick();
    endtask

    task automatic test_inv_err();
        tick(); invalid_req = 1; req_addr = 32'h4000; arready = 1;
        tick(); invalid_req = 0;
        n_cmp++; if ({araddr, arsnoop} !== {32'h4000, 4'b1011}) begin n_err++; $display("FAIL err_ar got %h exp %h", {araddr, arsnoop}, {32'h4000, 4'b1011}); end
        tick(); arready = 0; rvalid = 1; rdata = 32'hBAD0BAD0; rresp = 4'b1010;
        tick(); rvalid = 0;
        n_cmp++; if ({ace_ready, resp_err, rack} !== 3'b111) begin n_err++; $display("FAIL err_done got %b exp 111", {ace_ready, resp_err, rack}); end
        n_cmp++; if ({fill_data, fill_shared} !== {32'h12345678, 1'b0}) begin n_err++; $display("FAIL err_fill got %h exp %h", {fill_data, fill_shared}, {32'h12345678, 1'b0}); end
        tick();
        n_cmp++; if ({ace_ready, resp_err} !== 2'b00) begin n_err++; $display("FAIL err_clear got %b exp 00", {ace_ready, resp_err}); end
    endtask

    task automatic test_reset_mid();
        tick(); read_req = 1; req_addr = 32'h5000; arready = 1;
        tick(); read_req = 0;
        tick(); arready = 0;
        n_cmp++; if (rready !== 1'b1) begin n_err++; $display("FAIL rst_rwait got %b exp 1", rready); end
        #2 reset = 0; rvalid = 1; rdata = 32'h99999999; rresp = 4'b0000;
        #1;
        n_cmp++; if ({rready, arvalid, dbg_state, fill_data} !== {5'b0, 32'h0}) begin
            n_err++; $display("FAIL rst_async got %b/%0d/%h exp 00/0/0", {rready, arvalid}, dbg_state, fill_data); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if ({ace_ready, rready, rack} !== 3'b000) begin n_err++; $display("FAIL rst_hold%0d got %b exp 000", i, {ace_ready, rready, rack}); end
        end
        reset = 1; rvalid = 0;
        tick(); read_req = 1; req_addr = 32'h5040; arready = 1;
        tick(); read_req = 0;
        n_cmp++; if ({arvalid, araddr} !== {1'b1, 32'h5040}) begin n_err++; $display("FAIL rst_new_ar got %h exp %h", {arvalid, araddr}, {1'b1, 32'h5040}); end
        tick(); arready = 0; rvalid = 1; rdata = 32'hCAFEF00D; rresp = 4'b1000;
        tick(); rvalid = 0;
        n_cmp++; if ({ace_ready, rack, fill_data, fill_shared} !== {2'b11, 32'hCAFEF00D, 1'b1}) begin
            n_err++; $display("FAIL rst_new_done got %b/%h/%b exp 11/cafef00d/1", {ace_ready, rack}, fill_data, fill_shared); end
        tick();
    endtask

    task automatic test_back_to_back();
        tick(); write_req = 1; req_addr = 32'h6000; wb_data = 32'h0F0F0F0F; awready = 1; wready = 0;
        tick();
        n_cmp++; if ({awvalid, wvalid} !== 2'b11) begin n_err++; $display("FAIL b2b_valids got %b exp 11", {awvalid, wvalid}); end
        tick(); awready = 0; wready = 1;
        n_cmp++; if ({awvalid, wvalid, bready} !== 3'b010) begin n_err++; $display("FAIL b2b_aw_first got %b exp 010", {awvalid, wvalid, bready}); end
        tick(); wready = 0;
        n_cmp++; if ({wvalid, bready} !== 2'b01) begin n_err++; $display("FAIL b2b_bwait got %b exp 01", {wvalid, bready}); end
        bvalid = 1; bresp = 2'b10;
        tick(); bvalid = 0; read_req = 1;
        n_cmp++; if ({ace_ready, wack, resp_err} !== 3'b111) begin n_err++; $display("FAIL b2b_wb_done got %b exp 111", {ace_ready, wack, resp_err}); end
        tick(); write_req = 0; req_addr = 32'h7000; arready = 1;
        n_cmp++; if ({awvalid, arvalid, ace_ready} !== 3'b000) begin n_err++; $display("FAIL b2b_idle got %b exp 000", {awvalid, arvalid, ace_ready}); end
        tick(); read_req = 0;
        n_cmp++; if ({arvalid, arsnoop, araddr} !== {5'b1_0001, 32'h7000}) begin n_err++; $display("FAIL b2b_rd_ar got %h exp %h", {arvalid, arsnoop, araddr}, {5'b1_0001, 32'h7000}); end
        tick(); arready = 0; rvalid = 1; rdata = 32'h0BADF00D; rresp = 4'b0000;
        tick(); rvalid = 0;
        n_cmp++; if ({ace_ready, rack, resp_err, fill_data} !== {3'b110, 32'h0BADF00D}) begin
            n_err++; $display("FAIL b2b_rd_done got %b/%h exp 110/0badf00d", {ace_ready, rack, resp_err}, fill_data); end
        tick();
    endtask

    initial begin
        reset = 0;
        read_req = 0; write_req = 0; invalid_req = 0; req_addr = '0; wb_data = '0;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1;
        test_read();
        test_write();
        test_priority();
        test_inv_err();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
